// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle register CPU; sync ROM fetch, req/ack data RAM, stack in RAM.
module cpu_core_p #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 16,
  parameter int DADDR_W = 16,
  parameter int NREGS   = 8,
  parameter int BP_IDX  = 2,
  parameter int SP_IDX  = 3,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               halted,
  output logic [IADDR_W-1:0] o_ip,
  output logic [2:0]         o_state,
  output logic [1:0]         o_flags
);
  localparam int SW = $clog2(DATA_W);
  localparam logic [4:0] OP_LD = 5'd1, OP_LN = 5'd2, OP_CP = 5'd3, OP_ST = 5'd4, OP_SHL = 5'd5,
                         OP_ADD = 5'd6, OP_SUB = 5'd7, OP_JMP = 5'd8, OP_JZ = 5'd9, OP_PUSH = 5'd10,
                         OP_POP = 5'd11, OP_HLT = 5'd12, OP_LNH = 5'd13;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, HALT = 3'd4} state_t;
  state_t state, nxt;
  logic [15:0] ir;
  logic [IADDR_W-1:0] ip, jt;
  // Eight slots always exist; slots at or above NREGS are never written, so they read as 0.
  logic [DATA_W-1:0] r [8];
  logic c, z;
  logic [4:0] op;
  logic [2:0] rd;
  logic [DATA_W-1:0] rdv, src, sp, maddr, wval;
  logic [DATA_W:0] alu;
  logic is_mem, is_alu, wen, done;
  assign imem_addr = ip;
  assign o_ip = ip;
  assign halted = state == HALT;
  assign o_state = state;
  assign o_flags = {c, z};
  always_comb begin
    op = ir[15:11];
    rd = ir[10:8];
    rdv = r[rd];
    src = ir[7] ? DATA_W'(ir[6:0]) : r[ir[2:0]];
    sp = r[SP_IDX];
    jt = IADDR_W'(ir[10:0]);
    is_mem = op inside {OP_LD, OP_ST, OP_PUSH, OP_POP};
    is_alu = op inside {OP_SHL, OP_ADD, OP_SUB};
    // The extra top bit is carry for ADD, borrow for SUB, and the last bit shifted out for SHL.
    alu = op == OP_ADD ? {1'b0, rdv} + {1'b0, src}
        : op == OP_SUB ? {1'b0, rdv} - {1'b0, src}
        : {1'b0, rdv} << src[SW-1:0];
    maddr = op == OP_PUSH ? sp - DATA_W'(1) : op == OP_POP ? sp : r[BP_IDX] + DATA_W'(ir[7:0]);
    done = state == MEM && dmem_ack;
    wen = (state == EXEC && (op inside {OP_LN, OP_LNH, OP_CP} || is_alu)) ||
          (done && (op == OP_LD || op == OP_POP));
    wval = done ? dmem_rdata
         : op == OP_LN ? {rdv[DATA_W-1:8], ir[7:0]}
         : op == OP_LNH ? DATA_W'({ir[7:0], rdv[7:0]})
         : op == OP_CP ? src
         : alu[DATA_W-1:0];
  end
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = DECODE;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = is_mem ? MEM : op == OP_HLT ? HALT : FETCH;
      MEM:     nxt = dmem_ack ? FETCH : MEM;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= FETCH;
    else state <= nxt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ip <= '0;
      ir <= '0;
      c <= 1'b0;
      z <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 8; i++) r[i] <= i == SP_IDX ? SP_INIT : '0;
    end else begin
      if (state == DECODE) ir <= imem_rdata;
      if (state == EXEC) begin
        ip <= op == OP_HLT ? ip : (op == OP_JMP || (op == OP_JZ && z)) ? jt : ip + IADDR_W'(1);
        if (is_alu) begin
          c <= alu[DATA_W];
          z <= alu[DATA_W-1:0] == '0;
        end
        if (is_mem) begin
          dmem_req <= 1'b1;
          dmem_we <= op == OP_ST || op == OP_PUSH;
          dmem_addr <= DADDR_W'(maddr);
          dmem_wdata <= rdv;
        end
      end
      if (done) begin
        dmem_req <= 1'b0;
        if (op == OP_PUSH) r[SP_IDX] <= sp - DATA_W'(1);
        if (op == OP_POP) r[SP_IDX] <= sp + DATA_W'(1);
      end
      // Placed last so a POP into the stack pointer keeps the popped value.
      if (wen && 32'(rd) < NREGS) r[rd] <= wval;
    end
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed programs checked every cycle against an instruction-level ISA model.
module tb_cpu_core_p;
  logic clock = 1'b0, reset = 1'b0;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, o_ip;
  logic dmem_req, dmem_we, dmem_ack, halted;
  logic [2:0] o_state;
  logic [1:0] o_flags;
  int n_cmp = 0, n_fail = 0;
  bit [15:0] rom [256];
  bit [15:0] ram [65536];
  bit hold_ack = 0;
  int txn = 0;
  logic [15:0] wlog_a [$], wlog_d [$];
  bit [15:0] mr [8];
  bit [15:0] mram [65536];
  bit [15:0] mip;
  bit mc, mz;
  int prog_id = 0, first_mem_n = -1;

  cpu_core_p dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .halted(halted), .o_ip(o_ip),
    .o_state(o_state), .o_flags(o_flags)
  );

  always #5 clock = ~clock;
  always @(posedge clock) imem_rdata <= rom[imem_addr[7:0]];

  // Data RAM responder: first transfer acks after 3 cycles, then alternating 2 and 1.
  initial begin
    int cnt, d;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (dmem_req && !hold_ack) begin
        cnt++;
        d = txn == 0 ? 3 : (txn % 2 == 1 ? 2 : 1);
        if (cnt >= d) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            ram[dmem_addr] = dmem_wdata;
            wlog_a.push_back(dmem_addr);
            wlog_d.push_back(dmem_wdata);
          end else dmem_rdata = ram[dmem_addr];
          txn++;
          cnt = 0;
        end else dmem_ack = 1'b0;
      end else begin
        dmem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit [15:0] enc(input int op, input int rd, input int lo);
    return {op[4:0], rd[2:0], lo[7:0]};
  endfunction

  function automatic bit [15:0] jmp(input int op, input int t);
    return {op[4:0], t[10:0]};
  endfunction

  task automatic model_reset();
    foreach (mr[i]) mr[i] = '0;
    mip = '0;
    mc = 0;
    mz = 0;
  endtask

  // Executes one instruction of the ISA; reports the expected bus transfer, if any.
  task automatic model_step(output bit mem, output bit we, output bit [15:0] addr,
                            output bit [15:0] wdata, output bit hlt);
    bit [15:0] ins, a, src, pc;
    bit [4:0] op;
    bit [2:0] rd;
    int amt, s;
    pc = mip;
    ins = rom[pc[7:0]];
    op = ins[15:11];
    rd = ins[10:8];
    src = ins[7] ? {9'b0, ins[6:0]} : mr[ins[2:0]];
    a = mr[rd];
    mem = 0; we = 0; addr = '0; wdata = '0; hlt = 0;
    mip = pc + 16'd1;
    case (op)
      2:  mr[rd] = {a[15:8], ins[7:0]};
      13: mr[rd] = {ins[7:0], a[7:0]};
      3:  mr[rd] = src;
      5: begin
        amt = int'(src[3:0]);
        mr[rd] = 16'(int'(a) << amt);
        mc = amt > 0 && a[16-amt];
        mz = mr[rd] == 0;
      end
      6: begin
        s = int'(a) + int'(src);
        mr[rd] = 16'(s);
        mc = s > 32'hFFFF;
        mz = mr[rd] == 0;
      end
      7: begin
        mc = a < src;
        mr[rd] = a - src;
        mz = mr[rd] == 0;
      end
      8:  mip = {5'b0, ins[10:0]};
      9:  if (mz) mip = {5'b0, ins[10:0]};
      12: begin hlt = 1; mip = pc; end
      1: begin mem = 1; addr = mr[2] + ins[7:0]; mr[rd] = mram[addr]; end
      4: begin mem = 1; we = 1; addr = mr[2] + ins[7:0]; wdata = a; mram[addr] = a; end
      10: begin mem = 1; we = 1; addr = mr[3] - 16'd1; wdata = a; mram[addr] = a; mr[3] = addr; end
      11: begin mem = 1; addr = mr[3]; mr[3] = mr[3] + 16'd1; mr[rd] = mram[addr]; end
      default: ;
    endcase
  endtask

  // Hand-computed values that pin the model itself.
  task automatic pin_literals(input bit [15:0] pc);
    if (prog_id == 1 && pc == 16'h02) begin chk("lit_sub_r1", mr[1], 0); chk("lit_sub_flags", {mc, mz}, 2'b01); end
    if (prog_id == 1 && pc == 16'h22) begin chk("lit_wrap_r1", mr[1], 0); chk("lit_wrap_flags", {mc, mz}, 2'b11); end
    if (prog_id == 1 && pc == 16'h27) chk("lit_push_sp", mr[3], 16'hFFFF);
    if (prog_id == 1 && pc == 16'h29) begin chk("lit_pop_sp", mr[3], 0); chk("lit_pop_r5", mr[5], 16'h005A); end
    if (prog_id == 1 && pc == 16'h30) begin chk("lit_shl_r7", mr[7], 16'h0200); chk("lit_shl_flags", {mc, mz}, 2'b10); end
  endtask

  // Single compare process: walks the model one instruction at a time and checks every cycle.
  task automatic run_prog();
    bit mem, we, hlt, acked;
    bit [15:0] addr, wdata, pc;
    int n;
    for (int k = 0; k < 100; k++) begin
      chk("fetch_state", o_state, 0);
      chk("fetch_ip", o_ip, mip);
      chk("imem_addr", imem_addr, mip);
      chk("flags", o_flags, {mc, mz});
      chk("halted_run", halted, 0);
      chk("req_idle", dmem_req, 0);
      pc = mip;
      model_step(mem, we, addr, wdata, hlt);
      pin_literals(pc);
      @(negedge clock);
      chk("decode_state", o_state, 1);
      @(negedge clock);
      chk("exec_state", o_state, 2);
      chk("exec_req", dmem_req, 0);
      if (mem) begin
        n = 0;
        acked = 0;
        while (!acked && n < 20) begin
          @(negedge clock);
          n++;
          chk("mem_state", o_state, 3);
          chk("mem_req", dmem_req, 1);
          chk("mem_we", dmem_we, we);
          chk("mem_addr", dmem_addr, addr);
          if (we) chk("mem_wdata", dmem_wdata, wdata);
          acked = dmem_ack;
        end
        chk("mem_ack_seen", acked, 1);
        if (first_mem_n < 0) first_mem_n = n;
      end
      if (hlt) begin
        repeat (4) begin
          @(negedge clock);
          chk("halt_state", o_state, 4);
          chk("halted", halted, 1);
          chk("halt_ip", o_ip, pc);
          chk("halt_flags", o_flags, {mc, mz});
        end
        return;
      end
      @(negedge clock);
    end
    chk("program_halts", halted, 1);
  endtask

  initial begin
    bit [15:0] exp_a [6] = '{16'h0014, 16'hFFFF, 16'h0015, 16'h0016, 16'h0017, 16'h0018};
    bit [15:0] exp_d [6] = '{16'h005A, 16'h005A, 16'h005A, 16'h0000, 16'h0200, 16'h005A};
    int n;
    foreach (rom[i]) rom[i] = '0;
    rom[8'h00] = enc(2, 1, 8'h05);
    rom[8'h01] = enc(6, 1, 8'h83);
    rom[8'h02] = enc(7, 1, 8'h88);
    rom[8'h03] = jmp(9, 16'h20);
    rom[8'h04] = enc(12, 0, 0);
    rom[8'h20] = enc(2, 1, 8'hFF);
    rom[8'h21] = enc(13, 1, 8'hFF);
    rom[8'h22] = enc(6, 1, 8'h81);
    rom[8'h23] = enc(2, 2, 8'h10);
    rom[8'h24] = enc(2, 1, 8'h5A);
    rom[8'h25] = enc(4, 1, 8'h04);
    rom[8'h26] = enc(1, 4, 8'h04);
    rom[8'h27] = enc(10, 1, 0);
    rom[8'h28] = enc(2, 1, 8'h33);
    rom[8'h29] = enc(11, 5, 0);
    rom[8'h2A] = enc(4, 5, 8'h05);
    rom[8'h2B] = enc(3, 6, 8'h03);
    rom[8'h2C] = enc(4, 6, 8'h06);
    rom[8'h2D] = enc(7, 1, 8'h81);
    rom[8'h2E] = jmp(9, 16'h00);
    rom[8'h2F] = enc(2, 7, 8'h81);
    rom[8'h30] = enc(5, 7, 8'h89);
    rom[8'h31] = enc(4, 7, 8'h07);
    rom[8'h32] = jmp(8, 16'h40);
    rom[8'h33] = enc(12, 0, 0);
    rom[8'h40] = enc(4, 4, 8'h08);
    rom[8'h41] = enc(12, 0, 0);
    prog_id = 1;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_state", o_state, 0);
    chk("rst_ip", o_ip, 0);
    chk("rst_flags", o_flags, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b1;
    run_prog();
    chk("p1_st_latency", first_mem_n, 3);
    chk("p1_nwrites", wlog_a.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < wlog_a.size()) begin
        chk("p1_waddr", wlog_a[i], exp_a[i]);
        chk("p1_wdata", wlog_d[i], exp_d[i]);
      end
    reset = 1'b0;
    hold_ack = 1;
    foreach (rom[i]) rom[i] = '0;
    rom[0] = enc(2, 1, 8'h77);
    rom[1] = enc(7, 1, 8'hF8);
    rom[2] = enc(2, 3, 8'h40);
    rom[3] = enc(4, 1, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!dmem_req && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("p2_req", dmem_req, 1);
    chk("p2_addr", dmem_addr, 0);
    chk("p2_wdata", dmem_wdata, 16'hFFFF);
    chk("p2_flags", o_flags, 2'b10);
    repeat (2) @(negedge clock);
    chk("p2_req_held", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("p2_rst_req", dmem_req, 0);
    chk("p2_rst_state", o_state, 0);
    chk("p2_rst_ip", o_ip, 0);
    chk("p2_rst_flags", o_flags, 0);
    chk("p2_rst_halted", halted, 0);
    @(negedge clock);
    hold_ack = 0;
    foreach (rom[i]) rom[i] = '0;
    rom[0] = enc(4, 1, 8'h00);
    rom[1] = enc(10, 3, 0);
    rom[2] = jmp(9, 16'h10);
    rom[3] = enc(12, 0, 0);
    rom[16] = enc(12, 0, 0);
    wlog_a.delete();
    wlog_d.delete();
    prog_id = 3;
    model_reset();
    reset = 1'b1;
    run_prog();
    chk("p3_nwrites", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("p3_st_addr", wlog_a[0], 16'h0000);
      chk("p3_st_data", wlog_d[0], 16'h0000);
      chk("p3_push_addr", wlog_a[1], 16'hFFFF);
      chk("p3_push_data", wlog_d[1], 16'h0000);
    end
    chk("p3_halt_ip", o_ip, 16'h0003);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
